// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16x16 unsigned multiply / 16/16 unsigned divide sequencer that
// borrows an external combinational ALU for one add or subtract per clock.
module alu_muldiv_seq #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [3:0]  OP_ADD     = 4'b0000,
  parameter logic [3:0]  OP_SUB     = 4'b0001,
  parameter logic [3:0]  OP_NON     = 4'b1111
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [DATA_WIDTH-1:0] OPA,
  input  logic [DATA_WIDTH-1:0] OPB,
  output logic                  READY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RES_HI,
  output logic [DATA_WIDTH-1:0] RES_LO,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_S,
  input  logic [DATA_WIDTH-1:0] ALU_RES,
  input  logic [3:0]            ALU_FLAG
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   hi_reg;   // P_HI (multiply) or R (divide)
  logic [DATA_WIDTH-1:0]   lo_reg;   // P_LO (multiply) or Q (divide)
  logic [DATA_WIDTH-1:0]   m_reg;    // multiplicand or divisor
  logic [CNT_W-1:0]        cnt_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   div_t;
  logic                    alu_carry;
  logic                    unused_flags;

  // Shifted partial remainder; its 17th bit is hi_reg[DATA_WIDTH-1].
  assign div_t        = {hi_reg[DATA_WIDTH-2:0], lo_reg[DATA_WIDTH-1]};
  assign alu_carry    = ALU_FLAG[1];
  assign unused_flags = ^{ALU_FLAG[3:2], ALU_FLAG[0]};

  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          if (!MODE)          state_next = S_MUL;
          else if (OPB != '0) state_next = S_DIV;
          else                state_next = S_FIN;
        end
      end
      S_MUL:   if (cnt_reg == CNT_W'(1)) state_next = S_FIN;
      S_DIV:   if (cnt_reg == CNT_W'(1)) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    READY = 1'b0;
    DONE  = 1'b0;
    ALU_S = OP_NON;
    ALU_A = '0;
    ALU_B = '0;
    case (state_reg)
      S_IDLE: READY = 1'b1;
      S_MUL: begin
        ALU_S = OP_ADD;
        ALU_A = hi_reg;
        ALU_B = lo_reg[0] ? m_reg : '0;
      end
      S_DIV: begin
        ALU_S = OP_SUB;
        ALU_A = div_t;
        ALU_B = m_reg;
      end
      S_FIN:   DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      m_reg   <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            cnt_reg <= CNT_W'(DATA_WIDTH);
            err_reg <= 1'b0;
            if (!MODE) begin
              hi_reg <= '0;
              lo_reg <= OPB;
              m_reg  <= OPA;
            end else if (OPB != '0) begin
              hi_reg <= '0;
              lo_reg <= OPA;
              m_reg  <= OPB;
            end else begin
              hi_reg  <= OPA;
              lo_reg  <= '1;
              err_reg <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // 33-bit right shift keeps the adder carry as the new top bit.
          {hi_reg, lo_reg} <= {alu_carry, ALU_RES, lo_reg[DATA_WIDTH-1:1]};
          cnt_reg          <= cnt_reg - CNT_W'(1);
        end
        S_DIV: begin
          if (hi_reg[DATA_WIDTH-1] || !alu_carry) begin
            hi_reg <= ALU_RES;
            lo_reg <= {lo_reg[DATA_WIDTH-2:0], 1'b1};
          end else begin
            hi_reg <= div_t;
            lo_reg <= {lo_reg[DATA_WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign RES_HI = hi_reg;
  assign RES_LO = lo_reg;
  assign ERR    = err_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the shared ALU
// (add carry / subtract borrow on FLAG bit 1).
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, mode;
  logic [15:0] opa, opb;
  logic        ready, done, err;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_res;
  logic [3:0]  alu_s, alu_flag;
  logic        alu_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .OPA(opa), .OPB(opb),
    .READY(ready), .DONE(done), .ERR(err), .RES_HI(res_hi), .RES_LO(res_lo),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_S(alu_s), .ALU_RES(alu_res), .ALU_FLAG(alu_flag)
  );

  // External ALU: C = carry out on add, C = borrow (A<B) on subtract.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (alu_s)
      4'b0000: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: begin
        alu_res = alu_a - alu_b;
        alu_c   = (alu_a < alu_b);
      end
      default: ;
    endcase
  end
  assign alu_flag = {alu_res[15], (alu_res == 16'h0), alu_c, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ehi,
                        input logic [15:0] elo, input logic eerr, input int elat,
                        input logic [3:0] es, input int poke);
    int cyc;
    @(negedge clk);
    start = 1'b1; mode = m; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = 16'hDEAD; opb = 16'hBEEF;
    cyc = 1;
    check({name, " alu_s"}, {28'h0, alu_s}, {28'h0, es});
    check({name, " busy"}, {31'h0, ready}, 32'h0);
    while (!done && cyc < 40) begin
      if (cyc == poke) begin
        start = 1'b1; mode = ~m; opa = 16'h0005; opb = 16'h0000;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check({name, " latency"}, cyc, elat);
    check({name, " res_hi"}, {16'h0, res_hi}, {16'h0, ehi});
    check({name, " res_lo"}, {16'h0, res_lo}, {16'h0, elo});
    check({name, " err"}, {31'h0, err}, {31'h0, eerr});
    @(negedge clk);
    check({name, " done_pulse"}, {31'h0, done}, 32'h0);
    check({name, " ready_after"}, {31'h0, ready}, 32'h1);
    check({name, " hold"}, {res_hi, res_lo, 15'h0, err}, {ehi, elo, 15'h0, eerr});
    $display("op %s: a=%h b=%h -> hi=%h lo=%h err=%0d latency=%0d",
             name, a, b, res_hi, res_lo, err, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'h0, ready}, 32'h1);
    check("reset done_err", {30'h0, done, err}, 32'h0);
    check("reset res", {res_hi, res_lo}, 32'h0);
    check("reset alu", {alu_s, alu_a, alu_b[11:0]}, {4'hF, 28'h0});
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released: ready=%0d alu_s=%h", ready, alu_s);

    run_op("mul1",   1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17, 4'h0, 0);
    run_op("mulmax", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 4'h0, 0);
    run_op("mulzero",1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 4'h0, 0);
    run_op("div1",   1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0, 17, 4'h1, 0);
    run_op("div3",   1'b1, 16'hFFFF, 16'h0003, 16'h0000, 16'h5555, 1'b0, 17, 4'h1, 0);
    run_op("divt16", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17, 4'h1, 0);
    run_op("div0",   1'b1, 16'hABCD, 16'h0000, 16'hABCD, 16'hFFFF, 1'b1,  1, 4'hF, 0);
    run_op("divclr", 1'b1, 16'h0064, 16'h000A, 16'h0000, 16'h000A, 1'b0, 17, 4'h1, 0);
    run_op("mulpoke",1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17, 4'h0, 5);

    // Abort a multiply with reset at iteration 8.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; opa = 16'hFFFF; opb = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort busy", {31'h0, ready}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort ready", {31'h0, ready}, 32'h1);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort res", {res_hi, res_lo}, 32'h0);
    check("abort alu_s", {28'h0, alu_s}, 32'hF);
    rst_n = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no_done", n_done, 0);
    check("abort idle", {31'h0, ready}, 32'h1);
    $display("abort: done pulses after reset=%0d ready=%0d", n_done, ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
